// File: rtl/layer_pass_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sched_pkg
// Shared definitions for the layer pass scheduler: default widths, the
// scheduler state encoding and the bit positions inside pass_flags.
// -----------------------------------------------------------------------------
package sched_pkg;

    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned FLAG_WIDTH     = 4;
    localparam int unsigned BYTE_CNT_WIDTH = 16;

    // Bit positions inside pass_flags
    localparam int unsigned FLAG_BIAS = 0;
    localparam int unsigned FLAG_RELU = 1;
    localparam int unsigned FLAG_ACC  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/layer_pass_scheduler_tile_addr_gen.sv
// -----------------------------------------------------------------------------
// tile_addr_gen
// Holds the four per-pass GLB base addresses of a layer and steps them with
// adders only (wrap modulo 2^ADDR_W).
//   load   : latch bases and strides, all address registers take the bases
//   step_d : next D tile  -> ifmap += ifmap_stride, weight += weight_stride
//   step_k : next K tile  -> ifmap reloads its latched base,
//                            weight/opsum/bias += their strides
// Ports
//   clk, rst (sync, active-low)
//   load, step_d, step_k         : control strobes (load has priority)
//   *_base_i, *_stride_i         : layer configuration, sampled on load
//   ifmap_o, weight_o, opsum_o, bias_o : current pass addresses
// -----------------------------------------------------------------------------
module tile_addr_gen
    import sched_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step_d,
    input  logic              step_k,
    input  logic [ADDR_W-1:0] ifmap_base_i,
    input  logic [ADDR_W-1:0] weight_base_i,
    input  logic [ADDR_W-1:0] opsum_base_i,
    input  logic [ADDR_W-1:0] bias_base_i,
    input  logic [ADDR_W-1:0] ifmap_stride_i,
    input  logic [ADDR_W-1:0] weight_stride_i,
    input  logic [ADDR_W-1:0] opsum_stride_i,
    input  logic [ADDR_W-1:0] bias_stride_i,
    output logic [ADDR_W-1:0] ifmap_o,
    output logic [ADDR_W-1:0] weight_o,
    output logic [ADDR_W-1:0] opsum_o,
    output logic [ADDR_W-1:0] bias_o
);

    logic [ADDR_W-1:0] ifmap_base_q;
    logic [ADDR_W-1:0] ifmap_stride_q;
    logic [ADDR_W-1:0] weight_stride_q;
    logic [ADDR_W-1:0] opsum_stride_q;
    logic [ADDR_W-1:0] bias_stride_q;
    logic [ADDR_W-1:0] ifmap_q;
    logic [ADDR_W-1:0] weight_q;
    logic [ADDR_W-1:0] opsum_q;
    logic [ADDR_W-1:0] bias_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ifmap_base_q    <= '0;
            ifmap_stride_q  <= '0;
            weight_stride_q <= '0;
            opsum_stride_q  <= '0;
            bias_stride_q   <= '0;
            ifmap_q         <= '0;
            weight_q        <= '0;
            opsum_q         <= '0;
            bias_q          <= '0;
        end else if (load) begin
            ifmap_base_q    <= ifmap_base_i;
            ifmap_stride_q  <= ifmap_stride_i;
            weight_stride_q <= weight_stride_i;
            opsum_stride_q  <= opsum_stride_i;
            bias_stride_q   <= bias_stride_i;
            ifmap_q         <= ifmap_base_i;
            weight_q        <= weight_base_i;
            opsum_q         <= opsum_base_i;
            bias_q          <= bias_base_i;
        end else if (step_d) begin
            ifmap_q  <= ifmap_q + ifmap_stride_q;
            weight_q <= weight_q + weight_stride_q;
        end else if (step_k) begin
            // Weights are laid out tile after tile across the whole layer,
            // so they keep stepping; the ifmap restarts for each K tile.
            ifmap_q  <= ifmap_base_q;
            weight_q <= weight_q + weight_stride_q;
            opsum_q  <= opsum_q + opsum_stride_q;
            bias_q   <= bias_q + bias_stride_q;
        end
    end

    assign ifmap_o  = ifmap_q;
    assign weight_o = weight_q;
    assign opsum_o  = opsum_q;
    assign bias_o   = bias_q;

endmodule

// File: rtl/layer_pass_scheduler.sv
// -----------------------------------------------------------------------------
// layer_pass_scheduler
// Walks one convolution layer as K (outer) x D (inner) tile passes through
// the token engine / conv unit pair. Each pass: drive bases, flags and tile
// indices, pulse pass_start, wait for pass_done.
// Ports
//   clk, rst (sync, active-low)
//   layer_start, abort            : layer-level control
//   cfg_*                         : layer configuration, latched on start
//   pass_done                     : pass completion pulse from token engine
//   pass_start, base_*, pass_tile_n, pass_flags, tile_k_idx, tile_d_idx
//                                 : per-pass outputs to token engine
//   busy, layer_done, err_spurious_done : status
// Optional build macro SCHED_PERF_CNT_EN adds perf_busy_cycles and
// perf_wait_cycles (saturating, cleared on an accepted layer_start).
// -----------------------------------------------------------------------------
module layer_pass_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_WIDTH,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned FLAG_W = FLAG_WIDTH,
    parameter int unsigned BYTE_W = BYTE_CNT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_num_k,
    input  logic [CNT_W-1:0]  cfg_num_d,
    input  logic [ADDR_W-1:0] cfg_ifmap_base,
    input  logic [ADDR_W-1:0] cfg_weight_base,
    input  logic [ADDR_W-1:0] cfg_opsum_base,
    input  logic [ADDR_W-1:0] cfg_bias_base,
    input  logic [ADDR_W-1:0] cfg_ifmap_stride,
    input  logic [ADDR_W-1:0] cfg_weight_stride,
    input  logic [ADDR_W-1:0] cfg_opsum_stride,
    input  logic [ADDR_W-1:0] cfg_bias_stride,
    input  logic [BYTE_W-1:0] cfg_tile_n,
    input  logic              cfg_bias_en,
    input  logic              cfg_relu_en,
    input  logic              pass_done,
    output logic              pass_start,
    output logic [ADDR_W-1:0] base_ifmap,
    output logic [ADDR_W-1:0] base_weight,
    output logic [ADDR_W-1:0] base_opsum,
    output logic [ADDR_W-1:0] base_bias,
    output logic [BYTE_W-1:0] pass_tile_n,
    output logic [FLAG_W-1:0] pass_flags,
    output logic [CNT_W-1:0]  tile_k_idx,
    output logic [CNT_W-1:0]  tile_d_idx,
    output logic              busy,
    output logic              layer_done,
    output logic              err_spurious_done
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       perf_busy_cycles,
    output logic [31:0]       perf_wait_cycles
`endif
);

    sched_state_e      state_q;
    logic              pass_start_q;
    logic              layer_done_q;
    logic              busy_q;
    logic              err_q;
    logic [CNT_W-1:0]  k_q;
    logic [CNT_W-1:0]  d_q;
    logic [CNT_W-1:0]  num_k_q;
    logic [CNT_W-1:0]  num_d_q;
    logic [BYTE_W-1:0] tile_n_q;
    logic              bias_en_q;
    logic              relu_en_q;

    logic d_last;
    logic k_last;
    logic accept;
    logic advance;
    logic step_d;
    logic step_k;

    always_comb begin
        d_last  = (d_q == num_d_q - CNT_W'(1));
        k_last  = (k_q == num_k_q - CNT_W'(1));
        accept  = (state_q == S_IDLE) && layer_start;
        advance = (state_q == S_NEXT) && !abort;
        step_d  = advance && !d_last;
        step_k  = advance && d_last && !k_last;
    end

    tile_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk             (clk),
        .rst             (rst),
        .load            (accept),
        .step_d          (step_d),
        .step_k          (step_k),
        .ifmap_base_i    (cfg_ifmap_base),
        .weight_base_i   (cfg_weight_base),
        .opsum_base_i    (cfg_opsum_base),
        .bias_base_i     (cfg_bias_base),
        .ifmap_stride_i  (cfg_ifmap_stride),
        .weight_stride_i (cfg_weight_stride),
        .opsum_stride_i  (cfg_opsum_stride),
        .bias_stride_i   (cfg_bias_stride),
        .ifmap_o         (base_ifmap),
        .weight_o        (base_weight),
        .opsum_o         (base_opsum),
        .bias_o          (base_bias)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pass_start_q <= 1'b0;
            layer_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            k_q          <= '0;
            d_q          <= '0;
            num_k_q      <= '0;
            num_d_q      <= '0;
            tile_n_q     <= '0;
            bias_en_q    <= 1'b0;
            relu_en_q    <= 1'b0;
        end else begin
            pass_start_q <= 1'b0;
            layer_done_q <= 1'b0;
            if (pass_done && (state_q != S_WAIT)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (layer_start) begin
                        num_k_q   <= cfg_num_k;
                        num_d_q   <= cfg_num_d;
                        tile_n_q  <= cfg_tile_n;
                        bias_en_q <= cfg_bias_en;
                        relu_en_q <= cfg_relu_en;
                        k_q       <= '0;
                        d_q       <= '0;
                        busy_q    <= 1'b1;
                        // Accepting a layer clears the sticky error, unless a
                        // stray pass_done arrives in this very cycle.
                        err_q     <= pass_done;
                        if ((cfg_num_k == '0) || (cfg_num_d == '0)) begin
                            state_q      <= S_DONE;
                            layer_done_q <= 1'b1;
                        end else begin
                            state_q      <= S_ISSUE;
                            pass_start_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (pass_done) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (!d_last) begin
                        d_q          <= d_q + CNT_W'(1);
                        state_q      <= S_ISSUE;
                        pass_start_q <= 1'b1;
                    end else if (!k_last) begin
                        k_q          <= k_q + CNT_W'(1);
                        d_q          <= '0;
                        state_q      <= S_ISSUE;
                        pass_start_q <= 1'b1;
                    end else begin
                        state_q      <= S_DONE;
                        layer_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Flags derive from registered indices only, so they hold for a whole pass.
    always_comb begin
        pass_flags            = '0;
        pass_flags[FLAG_BIAS] = bias_en_q & (d_q == '0);
        pass_flags[FLAG_RELU] = relu_en_q & d_last;
        pass_flags[FLAG_ACC]  = (d_q != '0);
    end

    assign pass_start        = pass_start_q;
    assign layer_done        = layer_done_q;
    assign busy              = busy_q;
    assign err_spurious_done = err_q;
    assign tile_k_idx        = k_q;
    assign tile_d_idx        = d_q;
    assign pass_tile_n       = tile_n_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_wait_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_busy_q <= '0;
            perf_wait_q <= '0;
        end else if (accept) begin
            perf_busy_q <= '0;
            perf_wait_q <= '0;
        end else begin
            if (busy_q && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if ((state_q == S_WAIT) && (perf_wait_q != '1)) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign perf_busy_cycles = perf_busy_q;
    assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_layer_pass_scheduler.sv
module tb_layer_pass_scheduler;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 8;
    localparam int unsigned FW = 4;
    localparam int unsigned BW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          layer_start;
    logic          abort;
    logic [CW-1:0] cfg_num_k, cfg_num_d;
    logic [AW-1:0] cfg_ifmap_base, cfg_weight_base, cfg_opsum_base, cfg_bias_base;
    logic [AW-1:0] cfg_ifmap_stride, cfg_weight_stride, cfg_opsum_stride, cfg_bias_stride;
    logic [BW-1:0] cfg_tile_n;
    logic          cfg_bias_en, cfg_relu_en;
    logic          pass_done;
    logic          pass_start;
    logic [AW-1:0] base_ifmap, base_weight, base_opsum, base_bias;
    logic [BW-1:0] pass_tile_n;
    logic [FW-1:0] pass_flags;
    logic [CW-1:0] tile_k_idx, tile_d_idx;
    logic          busy, layer_done, err_spurious_done;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]   perf_busy_cycles, perf_wait_cycles;
`endif

    always #5 clk = ~clk;

    layer_pass_scheduler #(
        .ADDR_W (AW),
        .CNT_W  (CW),
        .FLAG_W (FW),
        .BYTE_W (BW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .layer_start       (layer_start),
        .abort             (abort),
        .cfg_num_k         (cfg_num_k),
        .cfg_num_d         (cfg_num_d),
        .cfg_ifmap_base    (cfg_ifmap_base),
        .cfg_weight_base   (cfg_weight_base),
        .cfg_opsum_base    (cfg_opsum_base),
        .cfg_bias_base     (cfg_bias_base),
        .cfg_ifmap_stride  (cfg_ifmap_stride),
        .cfg_weight_stride (cfg_weight_stride),
        .cfg_opsum_stride  (cfg_opsum_stride),
        .cfg_bias_stride   (cfg_bias_stride),
        .cfg_tile_n        (cfg_tile_n),
        .cfg_bias_en       (cfg_bias_en),
        .cfg_relu_en       (cfg_relu_en),
        .pass_done         (pass_done),
        .pass_start        (pass_start),
        .base_ifmap        (base_ifmap),
        .base_weight       (base_weight),
        .base_opsum        (base_opsum),
        .base_bias         (base_bias),
        .pass_tile_n       (pass_tile_n),
        .pass_flags        (pass_flags),
        .tile_k_idx        (tile_k_idx),
        .tile_d_idx        (tile_d_idx),
        .busy              (busy),
        .layer_done        (layer_done),
        .err_spurious_done (err_spurious_done)
`ifdef SCHED_PERF_CNT_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_wait_cycles  (perf_wait_cycles)
`endif
    );

    typedef struct {
        logic [7:0]  nk, nd;
        logic [31:0] ib, wb, ob, bb;
        logic [31:0] is, ws, os, bs;
        logic [15:0] tn;
        logic        ben, ren;
    } cfg_t;

    // Layer config, one probe pass with hand-computed expected outputs, and
    // the number of passes the layer must issue.
    typedef struct {
        cfg_t        cfg;
        int          pk, pd;
        logic [31:0] e_if, e_w, e_o, e_b;
        logic [3:0]  e_fl;
        int          e_passes;
    } vec_t;

    vec_t tbl[7];

    int   errors = 0;
    int   checks = 0;
    int   ps_count = 0;
    int   ld_count = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, count pulses, release pulse inputs.
    task automatic step();
        @(negedge clk);
        if (pass_start) ps_count++;
        if (layer_done) ld_count++;
        layer_start = 1'b0;
        pass_done   = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic drive_cfg(input cfg_t c);
        cfg_num_k         = c.nk;
        cfg_num_d         = c.nd;
        cfg_ifmap_base    = c.ib;
        cfg_weight_base   = c.wb;
        cfg_opsum_base    = c.ob;
        cfg_bias_base     = c.bb;
        cfg_ifmap_stride  = c.is;
        cfg_weight_stride = c.ws;
        cfg_opsum_stride  = c.os;
        cfg_bias_stride   = c.bs;
        cfg_tile_n        = c.tn;
        cfg_bias_en       = c.ben;
        cfg_relu_en       = c.ren;
    endtask

    function automatic cfg_t rand_cfg(input int maxk, input int maxd);
        cfg_t c;
        c.nk  = 8'($urandom_range(0, maxk));
        c.nd  = 8'($urandom_range(0, maxd));
        c.ib  = $urandom;
        c.wb  = $urandom;
        c.ob  = $urandom;
        c.bb  = $urandom;
        c.is  = $urandom;
        c.ws  = $urandom;
        c.os  = $urandom;
        c.bs  = $urandom;
        c.tn  = 16'($urandom);
        c.ben = 1'($urandom);
        c.ren = 1'($urandom);
        return c;
    endfunction

    // Inputs changing after acceptance must not disturb the running layer.
    task automatic scramble();
        drive_cfg(rand_cfg(255, 255));
    endtask

    // sel 0: pass_start, sel 1: layer_done. Bounded by maxc cycles.
    task automatic wait_for(input int sel, input int maxc, output bit found, output int lat);
        int i;
        found = 1'b0;
        lat   = 0;
        i     = 0;
        while (!found && i < maxc) begin
            step();
            i++;
            if ((sel == 0 && pass_start) || (sel == 1 && layer_done)) begin
                found = 1'b1;
                lat   = i;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pass_start"}, 64'(pass_start), 0);
        chk({tag, "_bases"}, {base_ifmap | base_weight | base_opsum | base_bias}, 0);
        chk({tag, "_tile_n"}, 64'(pass_tile_n), 0);
        chk({tag, "_flags"}, 64'(pass_flags), 0);
        chk({tag, "_idx"}, {48'd0, tile_k_idx, tile_d_idx}, 0);
        chk({tag, "_status"}, {61'd0, busy, layer_done, err_spurious_done}, 0);
    endtask

    // Runs a whole layer against the reference: pass p=(k,d) uses
    // ifmap = ib + d*is, weight = wb + (k*D+d)*ws, opsum = ob + k*os,
    // bias = bb + k*bs. spur/abort/ign select the pass at which a stray
    // pass_done, an abort, or an ignored layer_start is injected (-1: none).
    task automatic run_layer(input vec_t v, input int spur_pass, input int abort_pass,
                             input int ign_pass, input int dmin, input int dmax);
        int          nk, nd, total, p, lat, dly, ps0, ld0;
        bit          found;
        logic [31:0] ei, ew, eo, eb;
        logic [3:0]  ef;
        nk    = int'(v.cfg.nk);
        nd    = int'(v.cfg.nd);
        total = nk * nd;
        drive_cfg(v.cfg);
        layer_start = 1'b1;
        exp_err     = 1'b0;
        ps0 = ps_count;
        ld0 = ld_count;
        if (total == 0) begin
            wait_for(1, 4, found, lat);
            chk("zero_done_latency", 64'(lat), 1);
            chk("zero_busy", 64'(busy), 1);
            step();
            chk("zero_busy_low", 64'(busy), 0);
            chk("zero_no_pass", 64'(ps_count - ps0), 0);
            chk("zero_one_done", 64'(ld_count - ld0), 1);
            return;
        end
        p = 0;
        for (int k = 0; k < nk; k++) begin
            for (int d = 0; d < nd; d++) begin
                wait_for(0, 12, found, lat);
                if (!found) begin
                    chk("pass_start_timeout", 0, 1);
                    abort = 1'b1;
                    step();
                    step();
                    return;
                end
                chk("pass_latency", 64'(lat), (p == 0) ? 64'd1 : 64'd2);
                if (p == 0) scramble();
                ei = v.cfg.ib + 32'(d) * v.cfg.is;
                ew = v.cfg.wb + 32'(k * nd + d) * v.cfg.ws;
                eo = v.cfg.ob + 32'(k) * v.cfg.os;
                eb = v.cfg.bb + 32'(k) * v.cfg.bs;
                ef = {1'b0, (d != 0), (v.cfg.ren && d == nd - 1), (v.cfg.ben && d == 0)};
                chk("base_ifmap", 64'(base_ifmap), 64'(ei));
                chk("base_weight", 64'(base_weight), 64'(ew));
                chk("base_opsum", 64'(base_opsum), 64'(eo));
                chk("base_bias", 64'(base_bias), 64'(eb));
                chk("pass_flags", 64'(pass_flags), 64'(ef));
                chk("tile_idx", {48'd0, tile_k_idx, tile_d_idx}, {48'd0, 8'(k), 8'(d)});
                chk("tile_n", 64'(pass_tile_n), 64'(v.cfg.tn));
                chk("busy_in_pass", 64'(busy), 1);
                chk("err_flag", 64'(err_spurious_done), 64'(exp_err));
                if (v.pk == k && v.pd == d) begin
                    chk("vec_ifmap", 64'(base_ifmap), 64'(v.e_if));
                    chk("vec_weight", 64'(base_weight), 64'(v.e_w));
                    chk("vec_opsum", 64'(base_opsum), 64'(v.e_o));
                    chk("vec_bias", 64'(base_bias), 64'(v.e_b));
                    chk("vec_flags", 64'(pass_flags), 64'(v.e_fl));
                end
                if (p == spur_pass) begin
                    pass_done = 1'b1;   // lands in the ISSUE cycle
                    exp_err   = 1'b1;
                    step();
                    chk("spurious_sets_err", 64'(err_spurious_done), 1);
                    repeat (3) step();
                    chk("spurious_no_advance", 64'(ps_count - ps0), 64'(p + 1));
                    chk("spurious_same_d", 64'(tile_d_idx), 64'(d));
                end
                dly = $urandom_range(dmin, dmax);
                repeat (dly) step();
                if (p == ign_pass) begin
                    layer_start = 1'b1;
                    step();
                    chk("ignored_start_busy", 64'(busy), 1);
                    chk("ignored_start_addr", 64'(base_ifmap), 64'(ei));
                    chk("ignored_start_err", 64'(err_spurious_done), 64'(exp_err));
                end
                if (p == abort_pass) begin
                    abort     = 1'b1;
                    pass_done = 1'b1;   // abort must win
                    step();
                    chk("abort_idle", 64'(busy), 0);
                    repeat (4) step();
                    chk("abort_no_done", 64'(ld_count - ld0), 0);
                    chk("abort_no_pass", 64'(ps_count - ps0), 64'(p + 1));
                    return;
                end
                chk("pass_start_one_cycle", 64'(pass_start), 0);
                chk("stable_weight", 64'(base_weight), 64'(ew));
                pass_done = 1'b1;
                p++;
            end
        end
        wait_for(1, 6, found, lat);
        chk("done_latency", 64'(lat), 2);
        chk("busy_in_done", 64'(busy), 1);
        step();
        chk("busy_after_done", 64'(busy), 0);
        chk("pass_count", 64'(ps_count - ps0), 64'(v.e_passes));
        chk("done_count", 64'(ld_count - ld0), 1);
    endtask

    function automatic vec_t mk(input cfg_t c, input int pk, input int pd,
                                input logic [31:0] ei, input logic [31:0] ew,
                                input logic [31:0] eo, input logic [31:0] eb,
                                input logic [3:0] ef, input int np);
        vec_t v;
        v.cfg = c; v.pk = pk; v.pd = pd;
        v.e_if = ei; v.e_w = ew; v.e_o = eo; v.e_b = eb; v.e_fl = ef;
        v.e_passes = np;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cfg_t c;
        vec_t rv;
        bit   found;
        int   lat, ps0, ld0;

        // K=2, D=3, distinct bases/strides
        c = '{nk: 8'd2, nd: 8'd3, ib: 32'h1000, wb: 32'h2000, ob: 32'h3000, bb: 32'h4000,
              is: 32'h40, ws: 32'h100, os: 32'h80, bs: 32'h10, tn: 16'h0200, ben: 1'b1, ren: 1'b1};
        tbl[0] = mk(c, 1, 0, 32'h1000, 32'h2300, 32'h3080, 32'h4010, 4'b0001, 6);
        tbl[1] = mk(c, 0, 1, 32'h1040, 32'h2100, 32'h3000, 32'h4000, 4'b0100, 6);
        tbl[2] = mk(c, 1, 2, 32'h1080, 32'h2500, 32'h3080, 32'h4010, 4'b0110, 6);
        // Address wrap at 2^32
        c = '{nk: 8'd1, nd: 8'd2, ib: 32'hFFFF_FFF0, wb: 32'hFFFF_FF00, ob: 32'h0, bb: 32'h0,
              is: 32'h20, ws: 32'h100, os: 32'h0, bs: 32'h0, tn: 16'h0010, ben: 1'b1, ren: 1'b0};
        tbl[3] = mk(c, 0, 1, 32'h10, 32'h0, 32'h0, 32'h0, 4'b0100, 2);
        // D=1: every pass is both first and last D tile
        c = '{nk: 8'd3, nd: 8'd1, ib: 32'h0, wb: 32'h100, ob: 32'h200, bb: 32'h300,
              is: 32'h4, ws: 32'h8, os: 32'h10, bs: 32'h20, tn: 16'h0040, ben: 1'b1, ren: 1'b1};
        tbl[4] = mk(c, 2, 0, 32'h0, 32'h110, 32'h220, 32'h340, 4'b0011, 3);
        // Zero tile counts
        c = '{nk: 8'd0, nd: 8'd5, ib: 32'h5, wb: 32'h6, ob: 32'h7, bb: 32'h8,
              is: 32'h1, ws: 32'h1, os: 32'h1, bs: 32'h1, tn: 16'h1, ben: 1'b1, ren: 1'b1};
        tbl[5] = mk(c, -1, -1, 0, 0, 0, 0, 0, 0);
        c.nk = 8'd4; c.nd = 8'd0;
        tbl[6] = mk(c, -1, -1, 0, 0, 0, 0, 0, 0);

        rst = 1'b0; layer_start = 1'b0; pass_done = 1'b0; abort = 1'b0;
        drive_cfg(tbl[0].cfg);
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b1;
        step();
        check_all_zero("idle");

        // Table vectors; first one with pass_done 5 cycles after pass_start
        run_layer(tbl[0], -1, -1, -1, 5, 5);
        for (int i = 1; i < 7; i++) run_layer(tbl[i], -1, -1, -1, 1, 4);

        // Stray pass_done during ISSUE, then a fresh layer clears the flag
        run_layer(tbl[1], 0, -1, -1, 1, 4);
        run_layer(tbl[2], -1, -1, -1, 1, 3);

        // Abort in WAIT of pass (0,1), then a clean restart from (0,0)
        run_layer(tbl[0], -1, 1, -1, 2, 4);
        run_layer(tbl[0], -1, -1, -1, 1, 3);

        // layer_start while busy is dropped
        run_layer(tbl[2], -1, -1, 2, 2, 4);

        // Reset in the middle of a pass
        drive_cfg(tbl[0].cfg);
        layer_start = 1'b1;
        wait_for(0, 4, found, lat);
        chk("rst_seq_started", 64'(found), 1);
        step();
        step();
        rst = 1'b0;
        step();
        check_all_zero("mid_reset");
        rst = 1'b1;
        exp_err = 1'b0;
        ps0 = ps_count;
        ld0 = ld_count;
        repeat (4) step();
        chk("post_reset_quiet", 64'(ps_count - ps0 + ld_count - ld0), 0);

        // Randomized layers
        for (int i = 0; i < 25; i++) begin
            rv = mk(rand_cfg(3, 3), -1, -1, 0, 0, 0, 0, 0, 0);
            rv.e_passes = int'(rv.cfg.nk) * int'(rv.cfg.nd);
            run_layer(rv, -1, -1, -1, 1, 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_pass_scheduler.md
# layer_pass_scheduler

Sequences one convolution layer as a series of tile passes through the token engine / conv unit pair. On `layer_start` it latches the layer's tiling configuration, then walks K tiles (outer) and D tiles (inner). For each pass it drives the base addresses and flags and issues a one-cycle `pass_start`, then waits for `pass_done`. It sits between the layer-level controller and the `PASS_START`/`BASE_*`/`pass_flags` inputs of the token engine.

## Interface
Parameters:
- `ADDR_W`, default `ADDR_WIDTH` (32): GLB address width.
- `CNT_W`, default 8: tile counter width.
- `FLAG_W`, default `FLAG_WIDTH` (4): pass flag width.
- `BYTE_W`, default `BYTE_CNT_WIDTH`: width of the tile byte count.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-low.
- `layer_start`, input, 1: one-cycle pulse that starts a layer. Ignored while `busy`.
- `abort`, input, 1: returns the block to IDLE from any state.
- `cfg_num_k`, input, CNT_W: number of K (output-channel) tiles.
- `cfg_num_d`, input, CNT_W: number of D (input-channel) tiles.
- `cfg_ifmap_base`, `cfg_weight_base`, `cfg_opsum_base`, `cfg_bias_base`, input, ADDR_W each: layer base addresses.
- `cfg_ifmap_stride`, `cfg_weight_stride`, `cfg_opsum_stride`, `cfg_bias_stride`, input, ADDR_W each: per-tile address increments.
- `cfg_tile_n`, input, BYTE_W: bytes per tile. Passed through unchanged.
- `cfg_bias_en`, `cfg_relu_en`, input, 1 each: layer-level enables.
- `pass_done`, input, 1: one-cycle pulse from the token engine.
- `pass_start`, output, 1: one-cycle pass issue pulse.
- `base_ifmap`, `base_weight`, `base_opsum`, `base_bias`, output, ADDR_W each: addresses for the current pass.
- `pass_tile_n`, output, BYTE_W: byte count for the current pass.
- `pass_flags`, output, FLAG_W: flags for the current pass.
- `tile_k_idx`, `tile_d_idx`, output, CNT_W each: index of the current pass.
- `busy`, output, 1: high in every state except IDLE.
- `layer_done`, output, 1: one-cycle pulse when the layer completes.
- `err_spurious_done`, output, 1: sticky error flag.

## Operation
- **States:** IDLE, ISSUE, WAIT, NEXT, DONE.
- **IDLE:** on `layer_start`:
  - latch all `cfg_*` inputs;
  - load the address registers with the bases;
  - clear `k` and `d`;
  - go to ISSUE.
  - If `cfg_num_k==0` or `cfg_num_d==0`, go to DONE instead.
- **ISSUE:** `pass_start=1` for exactly one cycle, then go to WAIT.
- **WAIT:** stay until `pass_done`, then go to NEXT.
- **NEXT:**
  - If `d < num_d-1`: `d++`, `base_ifmap += ifmap_stride`, `base_weight += weight_stride`, go to ISSUE.
  - Else if `k < num_k-1`:
    - `k++`, `d=0`;
    - `base_ifmap` reloads the latched ifmap base;
    - `base_weight += weight_stride`, `base_opsum += opsum_stride`, `base_bias += bias_stride`;
    - go to ISSUE.
  - Else go to DONE.
- **DONE:** `layer_done=1` for one cycle, then go to IDLE.
- **Flags** (combinational from state registers, held stable for the whole pass):
  - bit0 `bias_en` = `cfg_bias_en & (d==0)`;
  - bit1 `relu_en` = `cfg_relu_en & (d==num_d-1)`;
  - bit2 `acc_en` = `(d!=0)`, meaning accumulate onto the existing psum;
  - remaining bits are 0.
- **Address arithmetic:** adders only, no multipliers. Results wrap modulo 2^ADDR_W.
- **Spurious `pass_done`:** `pass_done` outside WAIT, including in the ISSUE cycle, is ignored for sequencing and sets `err_spurious_done`. The flag is cleared by reset or by the next accepted `layer_start`.
- **`abort`:** in any non-IDLE state, go to IDLE next cycle with no `layer_done`. If `abort` coincides with ISSUE, `pass_start` is still 1 that cycle. `abort` beats a simultaneous `pass_done`.
- **Reset values:** all outputs 0; state IDLE.

## Timing
- `layer_start` at cycle t → `pass_start` at t+1. Addresses, flags and indices are valid from t+1.
- `pass_done` at cycle u → NEXT at u+1 → next `pass_start` at u+2. Outputs change at u+2 and are stable until the following NEXT.
- Last `pass_done` at u → `layer_done` at u+2, `busy` low at u+3.
- Zero tile count: `layer_start` at t → `layer_done` at t+1.
- `busy` is a registered output: high from t+1 through the DONE cycle.
- `layer_start` while `busy` is dropped with no side effects.

## Configuration
- `SCHED_PERF_CNT_EN`
  - **Defined:** adds two 32-bit outputs:
    - `perf_busy_cycles`: counts cycles with `busy=1`;
    - `perf_wait_cycles`: counts cycles in WAIT.
  - Both counters clear on an accepted `layer_start` and saturate at all-ones.
  - **Undefined:** the ports and logic are absent. Sequencing is identical in both builds.

## Structure
- Shared package `sched_pkg`: state enum `sched_state_e`, flag bit index constants (`FLAG_BIAS=0`, `FLAG_RELU=1`, `FLAG_ACC=2`).
- One natural sub-module, `tile_addr_gen`: the four address registers with load, step and reload controls.

## Test plan
- `num_k=2`, `num_d=3`, `pass_done` 5 cycles after each `pass_start` → 6 passes in order (k,d) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), then one `layer_done`.
- Same layer with bases 0x1000, 0x2000, 0x3000, 0x4000 and strides 0x40, 0x100, 0x80, 0x10 → pass (1,0) drives ifmap 0x1000, weight 0x2300, opsum 0x3080, bias 0x4010. Flags are 001, 100, 110 for d=0,1,2 with both enables set.
- `num_d=0` → `layer_done` at t+1, no `pass_start`.
- `pass_done` injected during ISSUE → `err_spurious_done=1`, pass count unchanged. The next `layer_start` clears the flag.
- `abort` during WAIT of pass (0,1) → IDLE next cycle, no `layer_done`. A new `layer_start` restarts at (0,0) with the bases reloaded.
- `rst=0` mid-pass → all outputs 0 on the next edge. A `layer_start` while `busy` is ignored.
